// File: rtl/fpaddsub_execute_stage.sv
// FP add/sub execute stage: effective add/subtract of aligned mantissas with
// a registered output and a one-entry skid buffer behind a valid/ready handshake.
module fpaddsub_execute_stage #(
  parameter int EW = 8,
  parameter int MW = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_mmax,
  input  logic [MW-1:0] in_mmin,
  input  logic          in_g,
  input  logic          in_r,
  input  logic          in_s,
  input  logic          in_sa,
  input  logic          in_sb,
  input  logic          in_op,
  input  logic          in_maxab,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_exp,
  output logic [MW+3:0] out_sum,
  output logic          out_sign,
  output logic          out_eop,
  output logic          out_zero
);

  localparam int SW = MW + 4;

  // Operands are widened with a carry bit on top and G/R/S below; alignment
  // guarantees mmax-side >= mmin-side, so the subtract cannot wrap.
  function automatic logic [SW-1:0] addsub(input logic [MW-1:0] mmax,
                                           input logic [MW-1:0] mmin,
                                           input logic g,
                                           input logic r,
                                           input logic s,
                                           input logic eop);
    logic [SW-1:0] x;
    logic [SW-1:0] y;
    x = {1'b0, mmax, 3'b000};
    y = {1'b0, mmin, g, r, s};
    return eop ? (x - y) : (x + y);
  endfunction

  logic          sbe_p0;
  logic          eop_p0;
  logic          sign_p0;
  logic [SW-1:0] sum_p0;
  logic          zero_p0;
  logic          accept_p0;
  logic          load_p0;

  logic          vld_p1;
  logic [EW-1:0] exp_p1;
  logic [SW-1:0] sum_p1;
  logic          sign_p1;
  logic          eop_p1;
  logic          zero_p1;

  logic          skid_vld_p1;
  logic [EW-1:0] skid_exp_p1;
  logic [SW-1:0] skid_sum_p1;
  logic          skid_sign_p1;
  logic          skid_eop_p1;
  logic          skid_zero_p1;

  // Stage p0: effective operation and arithmetic
  always_comb begin
    sbe_p0  = in_sb ^ in_op;
    eop_p0  = in_sa ^ sbe_p0;
    sum_p0  = addsub(in_mmax, in_mmin, in_g, in_r, in_s, eop_p0);
    zero_p0 = (sum_p0 == '0);
    // Exact zero is reported as +0 under round-to-nearest.
    sign_p0 = zero_p0 ? 1'b0 : (in_maxab ? sbe_p0 : in_sa);
  end

  assign in_ready  = ~rst & ~skid_vld_p1;
  assign accept_p0 = in_valid & in_ready;
  assign load_p0   = ~vld_p1 | out_ready;

  // Stage p1: output register and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      exp_p1      <= '0;
      sum_p1      <= '0;
      sign_p1     <= 1'b0;
      eop_p1      <= 1'b0;
      zero_p1     <= 1'b0;
    end else if (load_p0) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
        exp_p1      <= skid_exp_p1;
        sum_p1      <= skid_sum_p1;
        sign_p1     <= skid_sign_p1;
        eop_p1      <= skid_eop_p1;
        zero_p1     <= skid_zero_p1;
      end else if (accept_p0) begin
        vld_p1      <= 1'b1;
        exp_p1      <= in_exp;
        sum_p1      <= sum_p0;
        sign_p1     <= sign_p0;
        eop_p1      <= eop_p0;
        zero_p1     <= zero_p0;
      end else begin
        vld_p1      <= 1'b0;
      end
    end else if (accept_p0) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Skid data only matters while skid_vld_p1 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!load_p0 && accept_p0) begin
      skid_exp_p1  <= in_exp;
      skid_sum_p1  <= sum_p0;
      skid_sign_p1 <= sign_p0;
      skid_eop_p1  <= eop_p0;
      skid_zero_p1 <= zero_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_exp   = exp_p1;
  assign out_sum   = sum_p1;
  assign out_sign  = sign_p1;
  assign out_eop   = eop_p1;
  assign out_zero  = zero_p1;

endmodule

// File: tb/tb_fpaddsub_execute_stage.sv
// Directed bench for fpaddsub_execute_stage: arithmetic vector table plus
// backpressure, ordering and reset-during-stall sequences.
module tb_fpaddsub_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_exp;
  logic [24:0] in_mmax;
  logic [24:0] in_mmin;
  logic        in_g, in_r, in_s, in_sa, in_sb, in_op, in_maxab;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic [28:0] out_sum;
  logic        out_sign, out_eop, out_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpaddsub_execute_stage #(.EW(8), .MW(25)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_mmax(in_mmax), .in_mmin(in_mmin),
    .in_g(in_g), .in_r(in_r), .in_s(in_s),
    .in_sa(in_sa), .in_sb(in_sb), .in_op(in_op), .in_maxab(in_maxab),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sum(out_sum),
    .out_sign(out_sign), .out_eop(out_eop), .out_zero(out_zero)
  );

  typedef struct {
    logic [7:0]  exp;
    logic [24:0] mmax;
    logic [24:0] mmin;
    logic        g, r, s, sa, sb, op, maxab;
    logic [28:0] sum;
    logic        sign, eop, zero;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] e, input logic [24:0] mx, input logic [24:0] mn);
    in_exp = e; in_mmax = mx; in_mmin = mn;
    in_g = 1'b0; in_r = 1'b0; in_s = 1'b0;
    in_sa = 1'b0; in_sb = 1'b0; in_op = 1'b0; in_maxab = 1'b0;
  endtask

  initial begin
    //            exp    mmax          mmin          g     r     s     sa    sb    op    maxab  sum             sign  eop   zero
    vecs[0] = '{8'd127, 25'h1000000, 25'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 29'h10000000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd127, 25'h1000000, 25'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 29'h0000000,  1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'd127, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 29'h4000000,  1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'd127, 25'h1000000, 25'h0000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 29'h7FFFFFF,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'd100, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 29'h4000000,  1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'd100, 25'h1000000, 25'h0800000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 29'hC000000,  1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFE,  25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 29'h1FFFFFF5, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'd5,   25'h1000000, 25'h1000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 29'h0000000,  1'b0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_ops(8'd0, 25'h0, 25'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_sum", 32'(out_sum), 32'd0);
    chk("reset_out_exp", 32'(out_exp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic table, one op at a time with downstream ready.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_exp = vecs[i].exp; in_mmax = vecs[i].mmax; in_mmin = vecs[i].mmin;
      in_g = vecs[i].g; in_r = vecs[i].r; in_s = vecs[i].s;
      in_sa = vecs[i].sa; in_sb = vecs[i].sb; in_op = vecs[i].op; in_maxab = vecs[i].maxab;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_sum", i),   32'(out_sum),   32'(vecs[i].sum));
      chk($sformatf("v%0d_sign", i),  32'(out_sign),  32'(vecs[i].sign));
      chk($sformatf("v%0d_eop", i),   32'(out_eop),   32'(vecs[i].eop));
      chk($sformatf("v%0d_zero", i),  32'(out_zero),  32'(vecs[i].zero));
      chk($sformatf("v%0d_exp", i),   32'(out_exp),   32'(vecs[i].exp));
    end
    @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three back-to-back ops tagged by exponent 1,2,3.
    @(negedge clk);
    out_ready = 1'b0;
    set_ops(8'd1, 25'h1000000, 25'h1000000);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_exp", 32'(out_exp), 32'd1);
    chk("bp_ready_after_first", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_exp = 8'd2;
    @(posedge clk);
    #1;
    chk("bp_ready_skid_full", 32'(in_ready), 32'd0);
    chk("bp_hold_exp", 32'(out_exp), 32'd1);
    @(negedge clk);
    in_exp = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    chk("bp_stable_exp", 32'(out_exp), 32'd1);
    chk("bp_stable_sum", 32'(out_sum), 32'h10000000);

    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic xin;
      if (c > 0) @(negedge clk);
      xin = in_valid & in_ready;
      if (out_valid && out_ready) got.push_back(out_exp);
      @(posedge clk);
      #1;
      if (xin) in_valid = 1'b0;
    end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      e = (k < got.size()) ? got[k] : 8'hxx;
      chk($sformatf("bp_order%0d", k), 32'(e), 32'(k + 1));
    end
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while both entries are occupied.
    @(negedge clk);
    out_ready = 1'b0;
    set_ops(8'd9, 25'h1000000, 25'h0800000);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rs_full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    chk("rs_out_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rs_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rs_no_stale_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
